// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the 16-bit cs/we/ack bus.
// Master 0 is the CPU and master 1 is the UART debug master. One transaction
// is granted at a time. A per-grant cycle counter ends any transaction that
// the slave never acknowledges.

// Per-master return path: read data, ack and err for one master. A master
// that is not granted sees all zeros. A timeout forces the read data to zero
// and raises ack and err together.
module bus_arbiter_ret (
  input  logic        granted,
  input  logic        cs,
  input  logic        s_ack,
  input  logic        tmo,
  input  logic [15:0] s_dat,
  output logic [15:0] m_dat,
  output logic        m_ack,
  output logic        m_err
);

  // A master that has dropped cs gets no ack, even if the slave acks late.
  always_comb begin
    m_dat = 16'h0000;
    m_ack = 1'b0;
    m_err = 1'b0;
    if (granted) begin
      m_dat = tmo ? 16'h0000 : s_dat;
      m_ack = cs & (s_ack | tmo);
      m_err = cs & tmo;
    end
  end

endmodule

module bus_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_m0_addr,
  input  logic [15:0] i_m0_dat,
  output logic [15:0] o_m0_dat,
  input  logic        i_m0_we,
  input  logic        i_m0_cs,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  input  logic [15:0] i_m1_addr,
  input  logic [15:0] i_m1_dat,
  output logic [15:0] o_m1_dat,
  input  logic        i_m1_we,
  input  logic        i_m1_cs,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  output logic [15:0] o_s_addr,
  output logic [15:0] o_s_dat,
  input  logic [15:0] i_s_dat,
  output logic        o_s_we,
  output logic        o_s_cs,
  input  logic        i_s_ack,
  output logic [1:0]  o_grant
);

  localparam int NUM_M = 2;
  // When TIMEOUT is 0 this wraps to 255. The TIMEOUT != 0 term in tmo masks it.
  localparam logic [7:0] TMO_LAST = TIMEOUT - 8'd1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] dat;
    logic        we;
    logic        cs;
  } req_t;

  state_t                      state;
  logic                        last;   // 1 = master 1 was served last
  logic [7:0]                  tcnt;
  req_t [NUM_M-1:0]            req;
  req_t                        cur;
  logic [NUM_M-1:0]            gnt;
  logic [NUM_M-1:0]            m_cs;
  logic [NUM_M-1:0]            m_ack;
  logic [NUM_M-1:0]            m_err;
  logic [NUM_M-1:0][15:0]      m_rdat;
  logic                        tmo;

  assign req[0] = '{addr: i_m0_addr, dat: i_m0_dat, we: i_m0_we, cs: i_m0_cs};
  assign req[1] = '{addr: i_m1_addr, dat: i_m1_dat, we: i_m1_we, cs: i_m1_cs};
  assign m_cs   = {i_m1_cs, i_m0_cs};

  // The grant is decoded directly from the state register.
  assign gnt     = {state == GRANT1, state == GRANT0};
  assign o_grant = gnt;

  // Select the granted master's request. IDLE drives zeros onto the slave port.
  always_comb begin
    cur = '0;
    if (gnt[1])      cur = req[1];
    else if (gnt[0]) cur = req[0];
  end

  assign o_s_cs   = cur.cs;
  assign o_s_addr = cur.addr;
  assign o_s_dat  = cur.dat;
  assign o_s_we   = cur.we;

  // Timeout fires in the TIMEOUT-th granted cycle. tcnt is 0 in the first
  // granted cycle. A real ack in that same cycle takes priority.
  assign tmo = (TIMEOUT != 8'd0) && (state != IDLE) &&
               (tcnt == TMO_LAST) && !i_s_ack;

  for (genvar g = 0; g < NUM_M; g++) begin : g_ret
    bus_arbiter_ret u_ret (
      .granted (gnt[g]),
      .cs      (m_cs[g]),
      .s_ack   (i_s_ack),
      .tmo     (tmo),
      .s_dat   (i_s_dat),
      .m_dat   (m_rdat[g]),
      .m_ack   (m_ack[g]),
      .m_err   (m_err[g])
    );
  end

  assign o_m0_dat = m_rdat[0];
  assign o_m0_ack = m_ack[0];
  assign o_m0_err = m_err[0];
  assign o_m1_dat = m_rdat[1];
  assign o_m1_ack = m_ack[1];
  assign o_m1_err = m_err[1];

  // Round-robin FSM. A tie goes to the master not served last. A grant ends
  // on ack, on abort (cs dropped) or on timeout.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
      last  <= 1'b1;
      tcnt  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          tcnt <= 8'd0;
          if (m_cs[0] && (!m_cs[1] || last)) begin
            state <= GRANT0;
            last  <= 1'b0;
          end else if (m_cs[1]) begin
            state <= GRANT1;
            last  <= 1'b1;
          end
        end
        GRANT0, GRANT1: begin
          if (!cur.cs || i_s_ack || tmo) state <= IDLE;
          else                           tcnt  <= tcnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter. The main instance uses TIMEOUT=4. A second
// instance with TIMEOUT=0 shares the same inputs and shows that the timeout
// can be disabled. Inputs change 1 time unit after the rising edge, and
// outputs are sampled on the falling edge.
module tb_bus_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [15:0] i_m0_addr = '0, i_m0_dat = '0, i_m1_addr = '0, i_m1_dat = '0, i_s_dat = '0;
  logic        i_m0_we = 1'b0, i_m0_cs = 1'b0, i_m1_we = 1'b0, i_m1_cs = 1'b0, i_s_ack = 1'b0;
  logic [15:0] o_m0_dat, o_m1_dat, o_s_addr, o_s_dat;
  logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err, o_s_we, o_s_cs;
  logic [1:0]  o_grant;
  logic [15:0] nt_m0_dat, nt_m1_dat, nt_s_addr, nt_s_dat;
  logic        nt_m0_ack, nt_m0_err, nt_m1_ack, nt_m1_err, nt_s_we, nt_s_cs;
  logic [1:0]  nt_grant;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  bus_arbiter #(.TIMEOUT(8'd4)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_m0_addr(i_m0_addr), .i_m0_dat(i_m0_dat), .o_m0_dat(o_m0_dat), .i_m0_we(i_m0_we),
    .i_m0_cs(i_m0_cs), .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err),
    .i_m1_addr(i_m1_addr), .i_m1_dat(i_m1_dat), .o_m1_dat(o_m1_dat), .i_m1_we(i_m1_we),
    .i_m1_cs(i_m1_cs), .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err),
    .o_s_addr(o_s_addr), .o_s_dat(o_s_dat), .i_s_dat(i_s_dat), .o_s_we(o_s_we),
    .o_s_cs(o_s_cs), .i_s_ack(i_s_ack), .o_grant(o_grant)
  );

  bus_arbiter #(.TIMEOUT(8'd0)) dut_nt (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_m0_addr(i_m0_addr), .i_m0_dat(i_m0_dat), .o_m0_dat(nt_m0_dat), .i_m0_we(i_m0_we),
    .i_m0_cs(i_m0_cs), .o_m0_ack(nt_m0_ack), .o_m0_err(nt_m0_err),
    .i_m1_addr(i_m1_addr), .i_m1_dat(i_m1_dat), .o_m1_dat(nt_m1_dat), .i_m1_we(i_m1_we),
    .i_m1_cs(i_m1_cs), .o_m1_ack(nt_m1_ack), .o_m1_err(nt_m1_err),
    .o_s_addr(nt_s_addr), .o_s_dat(nt_s_dat), .i_s_dat(i_s_dat), .o_s_we(nt_s_we),
    .o_s_cs(nt_s_cs), .i_s_ack(i_s_ack), .o_grant(nt_grant)
  );

  // Advance to just after the next rising edge, where new inputs are applied.
  task automatic step();
    @(posedge i_clk); #1;
  endtask

  task automatic clear_inputs();
    i_m0_addr = '0; i_m0_dat = '0; i_m0_we = 1'b0; i_m0_cs = 1'b0;
    i_m1_addr = '0; i_m1_dat = '0; i_m1_we = 1'b0; i_m1_cs = 1'b0;
    i_s_dat = '0; i_s_ack = 1'b0;
  endtask

  // One-cycle reset pulse. Returns with reset low, at the start of a cycle.
  task automatic do_reset();
    step(); i_reset = 1'b1; clear_inputs();
    step(); i_reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge i_clk);
    checks++; if (o_grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b want 00", o_grant); end
    checks++; if ({o_s_cs, o_s_we} !== 2'b00) begin errors++; $display("FAIL rst_s_ctl: got %b want 00", {o_s_cs, o_s_we}); end
    checks++; if ({o_s_addr, o_s_dat} !== 32'h0) begin errors++; $display("FAIL rst_s_bus: got %h want 0", {o_s_addr, o_s_dat}); end
    checks++; if ({o_m0_ack, o_m0_err, o_m1_ack, o_m1_err} !== 4'b0) begin errors++; $display("FAIL rst_acks: got %b want 0000", {o_m0_ack, o_m0_err, o_m1_ack, o_m1_err}); end
    checks++; if ({o_m0_dat, o_m1_dat} !== 32'h0) begin errors++; $display("FAIL rst_mdat: got %h want 0", {o_m0_dat, o_m1_dat}); end
    step(); i_reset = 1'b0;
  endtask

  task automatic test_single_read();
    i_m0_cs = 1'b1; i_m0_addr = 16'h0100;
    // An ack arriving while in IDLE must be ignored.
    i_s_ack = 1'b1; i_s_dat = 16'h7777;
    @(negedge i_clk);
    checks++; if (o_s_cs !== 1'b0) begin errors++; $display("FAIL rd_k_scs: got %b want 0", o_s_cs); end
    checks++; if (o_m0_ack !== 1'b0) begin errors++; $display("FAIL rd_idle_ack: got %b want 0", o_m0_ack); end
    step(); i_s_ack = 1'b1; i_s_dat = 16'hBEEF;
    @(negedge i_clk);
    checks++; if (o_grant !== 2'b01) begin errors++; $display("FAIL rd_grant: got %b want 01", o_grant); end
    checks++; if (o_s_cs !== 1'b1) begin errors++; $display("FAIL rd_scs: got %b want 1", o_s_cs); end
    checks++; if (o_s_addr !== 16'h0100) begin errors++; $display("FAIL rd_addr: got %h want 0100", o_s_addr); end
    checks++; if (o_m0_ack !== 1'b1) begin errors++; $display("FAIL rd_ack: got %b want 1", o_m0_ack); end
    checks++; if (o_m0_dat !== 16'hBEEF) begin errors++; $display("FAIL rd_dat: got %h want beef", o_m0_dat); end
    checks++; if ({o_m0_err, o_m1_ack} !== 2'b00) begin errors++; $display("FAIL rd_err: got %b want 00", {o_m0_err, o_m1_ack}); end
    step(); i_m0_cs = 1'b0; i_s_ack = 1'b0; i_s_dat = '0;
    @(negedge i_clk);
    checks++; if ({o_grant, o_s_cs, o_m0_ack} !== 4'b0000) begin errors++; $display("FAIL rd_end: got %b want 0000", {o_grant, o_s_cs, o_m0_ack}); end
  endtask

  task automatic test_tie();
    do_reset();
    i_m0_cs = 1'b1; i_m0_addr = 16'h0200;
    i_m1_cs = 1'b1; i_m1_addr = 16'h0210; i_m1_we = 1'b1; i_m1_dat = 16'h1234;
    step();
    @(negedge i_clk);
    checks++; if (o_grant !== 2'b01) begin errors++; $display("FAIL tie_g0: got %b want 01", o_grant); end
    checks++; if (o_s_dat !== 16'h0000) begin errors++; $display("FAIL tie_sdat0: got %h want 0000", o_s_dat); end
    checks++; if (o_m0_ack !== 1'b0) begin errors++; $display("FAIL tie_wait: got %b want 0", o_m0_ack); end
    step(); i_s_ack = 1'b1; i_s_dat = 16'h5555;
    @(negedge i_clk);
    checks++; if ({o_m0_ack, o_m1_ack} !== 2'b10) begin errors++; $display("FAIL tie_ack0: got %b want 10", {o_m0_ack, o_m1_ack}); end
    checks++; if (o_m0_dat !== 16'h5555) begin errors++; $display("FAIL tie_dat0: got %h want 5555", o_m0_dat); end
    step(); i_m0_cs = 1'b0; i_s_ack = 1'b0; i_s_dat = '0;
    @(negedge i_clk);
    checks++; if (o_grant !== 2'b00) begin errors++; $display("FAIL tie_idle1: got %b want 00", o_grant); end
    checks++; if (o_s_dat !== 16'h0000) begin errors++; $display("FAIL tie_sdat_idle: got %h want 0000", o_s_dat); end
    step();
    @(negedge i_clk);
    checks++; if (o_grant !== 2'b10) begin errors++; $display("FAIL tie_g1: got %b want 10", o_grant); end
    checks++; if (o_s_dat !== 16'h1234) begin errors++; $display("FAIL tie_sdat1: got %h want 1234", o_s_dat); end
    checks++; if ({o_s_we, o_s_addr} !== {1'b1, 16'h0210}) begin errors++; $display("FAIL tie_we_addr1: got %h want 10210", {o_s_we, o_s_addr}); end
    step(); i_s_ack = 1'b1;
    @(negedge i_clk);
    checks++; if ({o_m0_ack, o_m1_ack} !== 2'b01) begin errors++; $display("FAIL tie_ack1: got %b want 01", {o_m0_ack, o_m1_ack}); end
    step(); i_m1_cs = 1'b0; i_s_ack = 1'b0;
    @(negedge i_clk);
    checks++; if (o_grant !== 2'b00) begin errors++; $display("FAIL tie_idle2: got %b want 00", o_grant); end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    int n0 = 0, n1 = 0;
    logic [1:0] exp_g;
    do_reset();
    // The slave acks every cycle. Acks that arrive in IDLE must be ignored.
    i_m0_cs = 1'b1; i_m1_cs = 1'b1; i_s_ack = 1'b1;
    i_m0_addr = 16'h0A00; i_m1_addr = 16'h0B00;
    for (int i = 0; i < 16; i++) begin
      step();
      @(negedge i_clk);
      exp_g = (i % 4 == 0) ? 2'b01 : (i % 4 == 2) ? 2'b10 : 2'b00;
      checks++; if (o_grant !== exp_g) begin errors++; $display("FAIL b2b_grant[%0d]: got %b want %b", i, o_grant, exp_g); end
      checks++; if ({o_m1_ack, o_m0_ack} !== exp_g) begin errors++; $display("FAIL b2b_ack[%0d]: got %b want %b", i, {o_m1_ack, o_m0_ack}, exp_g); end
      n0 += int'(o_m0_ack);
      n1 += int'(o_m1_ack);
    end
    checks++; if (n0 !== 4) begin errors++; $display("FAIL b2b_n0: got %0d want 4", n0); end
    checks++; if (n1 !== 4) begin errors++; $display("FAIL b2b_n1: got %0d want 4", n1); end
    step(); clear_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    i_m1_cs = 1'b1; i_m1_addr = 16'h0400; i_s_dat = 16'hABCD;
    for (int c = 1; c <= 20; c++) begin
      step();
      @(negedge i_clk);
      if (c < 4) begin
        checks++; if ({o_grant, o_m1_ack, o_m1_err} !== 4'b1000) begin errors++; $display("FAIL tmo_wait[%0d]: got %b want 1000", c, {o_grant, o_m1_ack, o_m1_err}); end
        checks++; if (o_m1_dat !== 16'hABCD) begin errors++; $display("FAIL tmo_passdat[%0d]: got %h want abcd", c, o_m1_dat); end
      end else if (c == 4) begin
        checks++; if ({o_m1_ack, o_m1_err} !== 2'b11) begin errors++; $display("FAIL tmo_fire: got %b want 11", {o_m1_ack, o_m1_err}); end
        checks++; if (o_m1_dat !== 16'h0000) begin errors++; $display("FAIL tmo_dat: got %h want 0000", o_m1_dat); end
        checks++; if ({o_m0_ack, o_m0_err} !== 2'b00) begin errors++; $display("FAIL tmo_m0: got %b want 00", {o_m0_ack, o_m0_err}); end
      end else if (c == 5) begin
        checks++; if ({o_s_cs, o_grant, o_m1_ack} !== 4'b0000) begin errors++; $display("FAIL tmo_after: got %b want 0000", {o_s_cs, o_grant, o_m1_ack}); end
      end
      checks++; if ({nt_grant, nt_m1_ack, nt_m1_err} !== 4'b1000) begin errors++; $display("FAIL nt_wait[%0d]: got %b want 1000", c, {nt_grant, nt_m1_ack, nt_m1_err}); end
    end
    step(); clear_inputs();
  endtask

  task automatic test_abort();
    do_reset();
    i_m0_cs = 1'b1; i_m0_addr = 16'h0500;
    step();
    step();
    @(negedge i_clk);
    checks++; if ({o_grant, o_m0_ack} !== 3'b010) begin errors++; $display("FAIL ab_g2: got %b want 010", {o_grant, o_m0_ack}); end
    step(); i_m0_cs = 1'b0; i_s_ack = 1'b1; i_s_dat = 16'h9999;
    @(negedge i_clk);
    checks++; if ({o_m0_ack, o_m0_err} !== 2'b00) begin errors++; $display("FAIL ab_noack: got %b want 00", {o_m0_ack, o_m0_err}); end
    checks++; if (o_s_cs !== 1'b0) begin errors++; $display("FAIL ab_scs: got %b want 0", o_s_cs); end
    step();
    @(negedge i_clk);
    checks++; if (o_grant !== 2'b00) begin errors++; $display("FAIL ab_idle: got %b want 00", o_grant); end
    checks++; if ({o_m0_ack, o_m0_err, o_m0_dat} !== 18'h0) begin errors++; $display("FAIL ab_late: got %h want 0", {o_m0_ack, o_m0_err, o_m0_dat}); end
    step(); clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_m1_cs = 1'b1; i_m1_we = 1'b1; i_m1_addr = 16'h0300; i_m1_dat = 16'h4321; i_s_dat = 16'h1111;
    step();
    @(negedge i_clk);
    checks++; if ({o_grant, o_s_cs} !== 3'b101) begin errors++; $display("FAIL rm_g1: got %b want 101", {o_grant, o_s_cs}); end
    step(); #2;
    i_reset = 1'b1;
    #1;
    checks++; if ({o_grant, o_s_cs, o_s_we} !== 4'b0000) begin errors++; $display("FAIL rm_async_ctl: got %b want 0000", {o_grant, o_s_cs, o_s_we}); end
    checks++; if ({o_s_addr, o_s_dat} !== 32'h0) begin errors++; $display("FAIL rm_async_bus: got %h want 0", {o_s_addr, o_s_dat}); end
    checks++; if ({o_m1_ack, o_m1_err, o_m1_dat} !== 18'h0) begin errors++; $display("FAIL rm_async_m1: got %h want 0", {o_m1_ack, o_m1_err, o_m1_dat}); end
    step(); i_reset = 1'b0; clear_inputs();
    i_m0_cs = 1'b1; i_m1_cs = 1'b1;
    step();
    @(negedge i_clk);
    checks++; if (o_grant !== 2'b01) begin errors++; $display("FAIL rm_tie: got %b want 01", o_grant); end
    step(); i_s_ack = 1'b1;
    @(negedge i_clk);
    checks++; if (o_m0_ack !== 1'b1) begin errors++; $display("FAIL rm_ack: got %b want 1", o_m0_ack); end
    step(); clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_back_to_back();
    test_timeout();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, one-slave arbiter for the 16-bit cs/we/ack bus. It lets the CPU (master 0) and the UART debug master (master 1) share the external memory bus. Masters are granted round-robin, one transaction at a time. A timeout terminates any transaction the slave never acknowledges, so a missing device cannot hang either master.

## Interface
Parameters:
- TIMEOUT, 8'd255: maximum number of granted cycles without i_s_ack before an error termination. Legal range 0..255; 0 disables the timeout.

Ports:
- i_clk  in  1  system clock; all state changes on the rising edge.
- i_reset  in  1  reset; one clock; reset is asynchronous and active-high.
- i_m0_addr  in  16  master 0 (CPU) address.
- i_m0_dat  in  16  master 0 write data.
- o_m0_dat  out  16  master 0 read data.
- i_m0_we  in  1  master 0 write enable.
- i_m0_cs  in  1  master 0 request; held until ack is seen.
- o_m0_ack  out  1  master 0 transaction complete, one-cycle pulse.
- o_m0_err  out  1  master 0 transaction terminated by timeout; pulses together with o_m0_ack.
- i_m1_addr, i_m1_dat, o_m1_dat, i_m1_we, i_m1_cs, o_m1_ack, o_m1_err: master 1 (UART master), same widths and meaning as master 0.
- o_s_addr  out  16  slave address.
- o_s_dat  out  16  slave write data.
- i_s_dat  in  16  slave read data, valid while i_s_ack=1.
- o_s_we  out  1  slave write enable.
- o_s_cs  out  1  slave select.
- i_s_ack  in  1  slave acknowledge.
- o_grant  out  2  one-hot grant status: bit0 = master 0, bit1 = master 1, 00 = idle.

## Operation
State machine: IDLE, GRANT0, GRANT1. Registers: state, last-served flag `last`, 8-bit timeout counter `tcnt`.

IDLE:
- No requests: stay in IDLE.
- Only m0 requesting: go to GRANT0.
- Only m1 requesting: go to GRANT1.
- Both requesting: grant the master not in `last`.
- On entering a GRANT state: tcnt <= 0, and `last` is set to the granted master.

GRANTn (n = 0 or 1):
- Slave port outputs: o_s_cs = i_mn_cs; o_s_addr, o_s_dat and o_s_we are muxed from master n.
- Return path: o_mn_ack = i_s_ack and o_mn_dat = i_s_dat, both combinational.
- i_s_ack=1 completes the transaction: next state IDLE.
- i_mn_cs=0 (master aborted): next state IDLE; no ack is generated, and any i_s_ack in that cycle is ignored.
- Otherwise tcnt increments.
- Timeout: if TIMEOUT≠0, tcnt == TIMEOUT-1 and i_s_ack=0, then o_mn_ack=1, o_mn_err=1 and o_mn_dat=16'h0000 in that cycle; next state IDLE.

Non-granted master, and both masters in IDLE: o_dat=0, ack=0, err=0.

IDLE slave port: o_s_cs=0, o_s_we=0, o_s_addr=0, o_s_dat=0.

o_grant is decoded directly from state.

Masters must deassert cs in the cycle after they see ack. A cs still high in IDLE is a new request.

## Timing
- Reset values: state=IDLE, `last`=master 1 (so the CPU wins the first tie), tcnt=0, every output 0.
- Reset asserted mid-transaction: the slave port drops to 0 immediately (asynchronous) and no ack is issued.
- Request latency: cs rises in cycle k (IDLE) → o_s_cs=1 in cycle k+1.
- Zero-wait slave (ack in cycle k+1): master sees ack in cycle k+1; arbiter is back in IDLE at k+2.
- Minimum transaction length is 2 cycles. Two masters both continuously requesting alternate, each served every 4 cycles.
- Timeout: err/ack asserts in the TIMEOUT-th granted cycle, counting the first granted cycle as 1; o_s_cs=0 the following cycle.
- i_s_ack seen while in IDLE is ignored.

## Test plan
- Reset release, then m0 read of addr 16'h0100, slave acks one cycle after cs with data 16'hBEEF → o_s_cs high at k+1, o_m0_ack=1 and o_m0_dat=16'hBEEF at k+1, o_grant=01 then 00.
- m0 and m1 both raise cs in the same cycle with 1-wait slave → m0 granted first, m1 next; grants alternate 01, 00, 10, 00; m1 write data 16'h1234 appears on o_s_dat only while o_grant=10.
- Both masters hold cs continuously for 8 transactions → exactly 4 acks each, strictly alternating, no starvation.
- TIMEOUT=4, slave never acks on m1 request → o_m1_ack and o_m1_err pulse in the 4th GRANT1 cycle with o_m1_dat=0; o_s_cs=0 the next cycle. With TIMEOUT=0 the same stimulus waits indefinitely.
- m0 drops cs after 2 granted cycles without ack → arbiter returns to IDLE, no ack or err; a late i_s_ack is ignored.
- i_reset asserted during GRANT1 with a slow slave → all outputs 0 asynchronously; after release the next tie is won by m0.
